// File: rtl/dh_pkg.sv
// dh_pkg: shared types and constants for the DH key-exchange controller.
// Latency: n/a (package). Backpressure: n/a.
// Holds the FSM state encoding, key widths and the default wait-state timeout.
package dh_pkg;

  localparam int SK_W            = 4;    // local secret exponent
  localparam int PK_W            = 64;   // public keys exchanged with the partner
  localparam int K_W             = 128;  // shared secret / AES key
  localparam int TIMEOUT_DEFAULT = 1024; // cycles allowed in a wait state

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    WAIT_MY,
    SEND,
    WAIT_PEER,
    FEED,
    DONE,
    ABORT
  } dh_state_e;

endpackage

// File: rtl/dh_key_ctrl_if.sv
// dh_key_ctrl_if: bundles the request, partner link, DH engine and AES key ports.
// Latency: n/a (wiring only). Backpressure: tx/rx/aes use valid/ready(ack).
// master = controller side, slave = environment (host, partner, DH engine, AES core).
interface dh_key_ctrl_if;
  import dh_pkg::*;

  logic            start;
  logic [SK_W-1:0] secret_key;
  logic            busy;
  logic            error;
  logic [PK_W-1:0] tx_key;
  logic            tx_valid;
  logic            tx_ready;
  logic [PK_W-1:0] rx_key;
  logic            rx_valid;
  logic            rx_ready;
  logic            dh_key_change;
  logic            dh_reset;
  logic            dh_val_p;
  logic [SK_W-1:0] dh_secret_key;
  logic [PK_W-1:0] dh_partner_key;
  logic [PK_W-1:0] dh_my_key;
  logic            dh_val_my_key;
  logic [K_W-1:0]  dh_K;
  logic            dh_val_K;
  logic [K_W-1:0]  aes_key;
  logic            aes_key_valid;
  logic            aes_key_ack;

  modport master (
    input  start, secret_key, tx_ready, rx_key, rx_valid,
           dh_my_key, dh_val_my_key, dh_K, dh_val_K, aes_key_ack,
    output busy, error, tx_key, tx_valid, rx_ready,
           dh_key_change, dh_reset, dh_val_p, dh_secret_key, dh_partner_key,
           aes_key, aes_key_valid
  );

  modport slave (
    output start, secret_key, tx_ready, rx_key, rx_valid,
           dh_my_key, dh_val_my_key, dh_K, dh_val_K, aes_key_ack,
    input  busy, error, tx_key, tx_valid, rx_ready,
           dh_key_change, dh_reset, dh_val_p, dh_secret_key, dh_partner_key,
           aes_key, aes_key_valid
  );

endinterface

// File: rtl/dh_watchdog.sv
// dh_watchdog: counts cycles spent in the current wait state, flags expiry.
// Latency: expired_o is combinational on the TIMEOUT_CYCLES-th cycle in a state.
// Ports: clk, reset (sync, active-low), enable_i (in a bounded wait state),
//        restart_i (first cycle of a new state), expired_o.
module dh_watchdog
  import dh_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  input  logic restart_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] elapsed;

  // elapsed = 1-based index of the current cycle within the state; the first
  // cycle of a state ignores whatever was left over from the previous one.
  assign elapsed   = restart_i ? CW'(1) : cnt_q;
  assign expired_o = enable_i && (elapsed >= CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= elapsed + CW'(1);
    end
  end

endmodule

// File: rtl/dh_key_ctrl.sv
// dh_key_ctrl: sequences one Diffie-Hellman key exchange and hands the result to AES.
// Latency: KICK->WAIT_MY one cycle; every capture registers on its handshake edge.
// Backpressure: tx held stable until tx_ready, aes_key held until aes_key_ack.
// Ports: clk, reset (sync, active-low), bus (dh_key_ctrl_if.master).
// Build option: DH_TIMEOUT_EN adds a per-state watchdog that aborts stalled waits.
module dh_key_ctrl
  import dh_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  dh_key_ctrl_if.master bus
);

  dh_state_e       state_q;
  logic [SK_W-1:0] sk_q;
  logic [PK_W-1:0] tx_key_q;
  logic [PK_W-1:0] rx_key_q;
  logic            rx_full_q;
  logic [K_W-1:0]  aes_key_q;
  logic            busy_q, error_q, tx_valid_q, rx_ready_q;
  logic            key_change_q, dh_reset_q, val_p_q, aes_valid_q;

  logic rx_hs, tx_hs, wd_expired;

  assign rx_hs = rx_ready_q & bus.rx_valid;
  assign tx_hs = tx_valid_q & bus.tx_ready;

`ifdef DH_TIMEOUT_EN
  dh_state_e prev_q;
  logic      wd_en;

  always_ff @(posedge clk) begin
    if (!reset) prev_q <= IDLE;
    else        prev_q <= state_q;
  end

  assign wd_en = state_q inside {WAIT_MY, SEND, WAIT_PEER, FEED};

  dh_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk       (clk),
    .reset     (reset),
    .enable_i  (wd_en),
    .restart_i (state_q != prev_q),
    .expired_o (wd_expired)
  );
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign wd_expired     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      sk_q         <= '0;
      tx_key_q     <= '0;
      rx_key_q     <= '0;
      rx_full_q    <= 1'b0;
      aes_key_q    <= '0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      tx_valid_q   <= 1'b0;
      rx_ready_q   <= 1'b0;
      key_change_q <= 1'b0;
      dh_reset_q   <= 1'b1;  // hold the engine in reset alongside us
      val_p_q      <= 1'b0;
      aes_valid_q  <= 1'b0;
    end else begin
      key_change_q <= 1'b0;
      dh_reset_q   <= 1'b0;

      // One-entry partner buffer: fills in any state while rx_ready is open.
      if (rx_hs) begin
        rx_key_q   <= bus.rx_key;
        rx_full_q  <= 1'b1;
        rx_ready_q <= 1'b0;
      end

      if (wd_expired) begin
        // Overrides the buffer fill above: a stalled exchange drops everything.
        state_q    <= ABORT;
        dh_reset_q <= 1'b1;
        error_q    <= 1'b1;
        tx_valid_q <= 1'b0;
        rx_full_q  <= 1'b0;
        rx_ready_q <= 1'b0;
        val_p_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              if (bus.secret_key != '0) begin
                state_q      <= KICK;
                sk_q         <= bus.secret_key;
                error_q      <= 1'b0;
                busy_q       <= 1'b1;
                key_change_q <= 1'b1;
                rx_ready_q   <= 1'b1;
                rx_full_q    <= 1'b0;
              end else begin
                error_q <= 1'b1;
              end
            end
          end
          KICK: state_q <= WAIT_MY;
          WAIT_MY: begin
            if (bus.dh_val_my_key) begin
              tx_key_q   <= bus.dh_my_key;
              tx_valid_q <= 1'b1;
              state_q    <= SEND;
            end
          end
          SEND: begin
            if (tx_hs) begin
              tx_valid_q <= 1'b0;
              // Partner key may already be buffered (or arrive this very edge).
              if (rx_full_q || rx_hs) begin
                val_p_q <= 1'b1;
                state_q <= FEED;
              end else begin
                state_q <= WAIT_PEER;
              end
            end
          end
          WAIT_PEER: begin
            if (rx_hs) begin
              val_p_q <= 1'b1;
              state_q <= FEED;
            end
          end
          FEED: begin
            if (bus.dh_val_K) begin
              aes_key_q   <= bus.dh_K;
              val_p_q     <= 1'b0;
              aes_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
          DONE: begin
            if (bus.aes_key_ack) begin
              aes_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              rx_full_q   <= 1'b0;
              state_q     <= IDLE;
            end
          end
          ABORT: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy           = busy_q;
  assign bus.error          = error_q;
  assign bus.tx_key         = tx_key_q;
  assign bus.tx_valid       = tx_valid_q;
  assign bus.rx_ready       = rx_ready_q;
  assign bus.dh_key_change  = key_change_q;
  assign bus.dh_reset       = dh_reset_q;
  assign bus.dh_val_p       = val_p_q;
  assign bus.dh_secret_key  = sk_q;
  assign bus.dh_partner_key = rx_key_q;
  assign bus.aes_key        = aes_key_q;
  assign bus.aes_key_valid  = aes_valid_q;

endmodule
